// File: rtl/regfile_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_arbiter
//
// Shares one 8x16 register file between two single-beat bus masters (A, B).
// One command is in flight at a time:
//   IDLE   -> latch the winner's command onto rf_*, pulse gnt_<winner>
//   ISSUE  -> register file samples the command at the closing edge
//   RDWAIT -> (reads only) capture rf_rd_data, pulse rvalid_<winner> next cycle
//
// Handshake: a requester raises req_x with we_x/addr_x/wdata_x stable and
// holds it until it sees gnt_x (a one-cycle pulse). It drops req_x in the
// cycle after gnt_x; a req_x still high when the arbiter is back in IDLE is
// taken as a new command. A read answers with a one-cycle rvalid_x pulse,
// and rdata_x holds its value until that requester's next read return.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   : ties go to the requester that was not granted last
//   undefined : fixed priority, A wins every tie (B can starve)
//
// Ports:
//   CLK, RST                    clock (rising edge), async active-low reset
//   req_x/we_x/addr_x/wdata_x   command from requester x (x = a, b)
//   gnt_x, rvalid_x, rdata_x    grant pulse, read-valid pulse, read data
//   rf_wr_data/rf_address/rf_wr_en/rf_rd_en   command to the register file
//   rf_rd_data                  registered read data from the register file
//   busy                        high whenever the FSM is not in IDLE
//   dbg_state                   current FSM state (IDLE=0, ISSUE=1, RDWAIT=2)
// ---------------------------------------------------------------------------
module regfile_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [ADDR_W-1:0] rf_address,
  output logic              rf_wr_en,
  output logic              rf_rd_en,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RDWAIT = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_owner_b;   // 1: command in flight belongs to B
  logic                r_is_read;
  logic                r_gnt_a;
  logic                r_gnt_b;
  logic                r_rvalid_a;
  logic                r_rvalid_b;
  logic [DATA_W-1:0]   r_rdata_a;
  logic [DATA_W-1:0]   r_rdata_b;
  logic [DATA_W-1:0]   r_rf_wr_data;
  logic [ADDR_W-1:0]   r_rf_address;
  logic                r_rf_wr_en;
  logic                r_rf_rd_en;
  logic                r_busy;

  logic                w_any_req;
  logic                w_pick_b;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;

  assign w_any_req = req_a | req_b;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers who was granted last; reset to B so A wins the first tie.
  logic r_last_grant_b;

  // B wins when alone, or on a tie when A was granted last.
  assign w_pick_b = req_b & (~req_a | ~r_last_grant_b);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_last_grant_b <= 1'b1;
    end else if (r_state == ST_IDLE && w_any_req) begin
      r_last_grant_b <= w_pick_b;
    end
  end
`else
  // Fixed priority: B only wins when A is not requesting.
  assign w_pick_b = req_b & ~req_a;
`endif

  assign w_we    = w_pick_b ? we_b    : we_a;
  assign w_addr  = w_pick_b ? addr_b  : addr_a;
  assign w_wdata = w_pick_b ? wdata_b : wdata_a;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= ST_IDLE;
      r_owner_b    <= 1'b0;
      r_is_read    <= 1'b0;
      r_gnt_a      <= 1'b0;
      r_gnt_b      <= 1'b0;
      r_rvalid_a   <= 1'b0;
      r_rvalid_b   <= 1'b0;
      r_rdata_a    <= '0;
      r_rdata_b    <= '0;
      r_rf_wr_data <= '0;
      r_rf_address <= '0;
      r_rf_wr_en   <= 1'b0;
      r_rf_rd_en   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // Pulses default low; each is raised for exactly one cycle below.
      r_gnt_a    <= 1'b0;
      r_gnt_b    <= 1'b0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_rf_address <= w_addr;
            r_rf_wr_data <= w_wdata;
            r_rf_wr_en   <= w_we;
            r_rf_rd_en   <= ~w_we;
            r_gnt_a      <= ~w_pick_b;
            r_gnt_b      <= w_pick_b;
            r_owner_b    <= w_pick_b;
            r_is_read    <= ~w_we;
            r_busy       <= 1'b1;
            r_state      <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          // The file has sampled the command at this edge; enables drop.
          r_rf_wr_en <= 1'b0;
          r_rf_rd_en <= 1'b0;
          if (r_is_read) begin
            r_state <= ST_RDWAIT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        ST_RDWAIT: begin
          // rf_rd_data is only meaningful here; it is ignored everywhere else.
          if (r_owner_b) begin
            r_rdata_b  <= rf_rd_data;
            r_rvalid_b <= 1'b1;
          end else begin
            r_rdata_a  <= rf_rd_data;
            r_rvalid_a <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_rf_wr_en <= 1'b0;
          r_rf_rd_en <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt_a      = r_gnt_a;
  assign gnt_b      = r_gnt_b;
  assign rvalid_a   = r_rvalid_a;
  assign rvalid_b   = r_rvalid_b;
  assign rdata_a    = r_rdata_a;
  assign rdata_b    = r_rdata_b;
  assign rf_wr_data = r_rf_wr_data;
  assign rf_address = r_rf_address;
  assign rf_wr_en   = r_rf_wr_en;
  assign rf_rd_en   = r_rf_rd_en;
  assign busy       = r_busy;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_regfile_arbiter.sv
module tb_regfile_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic              req_a = 1'b0, we_a = 1'b0;
  logic [ADDR_W-1:0] addr_a = '0;
  logic [DATA_W-1:0] wdata_a = '0;
  logic              req_b = 1'b0, we_b = 1'b0;
  logic [ADDR_W-1:0] addr_b = '0;
  logic [DATA_W-1:0] wdata_b = '0;
  logic              gnt_a, rvalid_a, gnt_b, rvalid_b;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic [DATA_W-1:0] rf_wr_data;
  logic [ADDR_W-1:0] rf_address;
  logic              rf_wr_en, rf_rd_en;
  logic [DATA_W-1:0] rf_rd_data;
  logic              busy;
  logic [1:0]        dbg_state;

  int checks = 0;
  int failures = 0;

  regfile_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .rf_wr_data(rf_wr_data), .rf_address(rf_address),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_rd_data(rf_rd_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Register file model: registered read data, 16'hFFFF when not reading.
  logic [DATA_W-1:0] mem [8];
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    rf_rd_data = 16'hFFFF;
  end
  always @(posedge CLK) begin
    if (rf_wr_en) mem[rf_address] <= rf_wr_data;
    rf_rd_data <= rf_rd_en ? mem[rf_address] : 16'hFFFF;
  end

  // Every-cycle mutual-exclusion monitor.
  always @(negedge CLK) begin
    if (RST) begin
      checks++;
      if (rf_wr_en && rf_rd_en) begin
        failures++;
        $display("FAIL rf_en_mutex: wr_en=%0b rd_en=%0b, required not both 1", rf_wr_en, rf_rd_en);
      end
      checks++;
      if (gnt_a && gnt_b) begin
        failures++;
        $display("FAIL gnt_mutex: gnt_a=%0b gnt_b=%0b, required not both 1", gnt_a, gnt_b);
      end
    end
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  // Raise a request, wait (bounded) for its grant, drop the request.
  // gnt_cyc = cycles from request to grant, -1 if no grant arrives in the window.
  task automatic send_cmd(input logic to_b, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wd, output int gnt_cyc);
    if (to_b) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd; end
    else      begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd; end
    gnt_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (to_b ? gnt_b : gnt_a) begin
        gnt_cyc = c;
        break;
      end
    end
    if (to_b) req_b = 1'b0; else req_a = 1'b0;
  endtask

  // Wait (bounded) for rvalid after the grant cycle; cyc=-1 on timeout.
  task automatic wait_rvalid(input logic to_b, output int cyc, output logic [DATA_W-1:0] data);
    cyc = -1;
    data = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (to_b ? rvalid_b : rvalid_a) begin
        cyc = c;
        data = to_b ? rdata_b : rdata_a;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if ({gnt_a, gnt_b, rvalid_a, rvalid_b, rf_wr_en, rf_rd_en, busy} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b, required 0000000",
               {gnt_a, gnt_b, rvalid_a, rvalid_b, rf_wr_en, rf_rd_en, busy});
    end
    checks++;
    if ({rdata_a, rdata_b, rf_wr_data, rf_address} !== '0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_data: rdata_a=%h rdata_b=%h wd=%h addr=%0d state=%0d, required all 0",
               rdata_a, rdata_b, rf_wr_data, rf_address, dbg_state);
    end
    RST = 1'b1;
  endtask

  task automatic test_write_a();
    @(negedge CLK);
    req_a = 1'b1; we_a = 1'b1; addr_a = 3'd3; wdata_a = 16'hBEEF;
    @(negedge CLK);  // cycle 1
    checks++;
    if (gnt_a !== 1'b1 || rf_wr_en !== 1'b1 || rf_rd_en !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL wr_cycle1_ctrl: gnt_a=%0b wr_en=%0b rd_en=%0b busy=%0b, required 1 1 0 1",
               gnt_a, rf_wr_en, rf_rd_en, busy);
    end
    checks++;
    if (rf_address !== 3'd3 || rf_wr_data !== 16'hBEEF) begin
      failures++;
      $display("FAIL wr_cycle1_cmd: addr=%0d data=%h, required 3 BEEF", rf_address, rf_wr_data);
    end
    req_a = 1'b0;
    @(negedge CLK);  // cycle 2
    checks++;
    if (busy !== 1'b0 || gnt_a !== 1'b0 || rf_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL wr_cycle2: busy=%0b gnt_a=%0b wr_en=%0b, required 0 0 0", busy, gnt_a, rf_wr_en);
    end
    @(negedge CLK);  // cycle 3
    checks++;
    if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0 || mem[3] !== 16'hBEEF) begin
      failures++;
      $display("FAIL wr_no_rvalid: rvalid_a=%0b rvalid_b=%0b mem3=%h, required 0 0 BEEF",
               rvalid_a, rvalid_b, mem[3]);
    end
  endtask

  task automatic test_read_b();
    req_b = 1'b1; we_b = 1'b0; addr_b = 3'd3;
    @(negedge CLK);  // cycle 1
    checks++;
    if (gnt_b !== 1'b1 || rf_rd_en !== 1'b1 || rf_wr_en !== 1'b0 || rf_address !== 3'd3) begin
      failures++;
      $display("FAIL rd_cycle1: gnt_b=%0b rd_en=%0b wr_en=%0b addr=%0d, required 1 1 0 3",
               gnt_b, rf_rd_en, rf_wr_en, rf_address);
    end
    req_b = 1'b0;
    @(negedge CLK);  // cycle 2
    checks++;
    if (rvalid_b !== 1'b0 || busy !== 1'b1 || rf_rd_en !== 1'b0 || dbg_state !== 2'd2) begin
      failures++;
      $display("FAIL rd_cycle2: rvalid_b=%0b busy=%0b rd_en=%0b state=%0d, required 0 1 0 2",
               rvalid_b, busy, rf_rd_en, dbg_state);
    end
    @(negedge CLK);  // cycle 3
    checks++;
    if (rvalid_b !== 1'b1 || rdata_b !== 16'hBEEF || busy !== 1'b0) begin
      failures++;
      $display("FAIL rd_cycle3: rvalid_b=%0b rdata_b=%h busy=%0b, required 1 BEEF 0",
               rvalid_b, rdata_b, busy);
    end
    checks++;
    if (rdata_a !== 16'h0000 || rvalid_a !== 1'b0) begin
      failures++;
      $display("FAIL rd_other_port: rdata_a=%h rvalid_a=%0b, required 0000 0", rdata_a, rvalid_a);
    end
    @(negedge CLK);  // cycle 4: pulse gone, data held despite FFFF on the bus
    checks++;
    if (rvalid_b !== 1'b0 || rdata_b !== 16'hBEEF) begin
      failures++;
      $display("FAIL rd_hold: rvalid_b=%0b rdata_b=%h, required 0 BEEF", rvalid_b, rdata_b);
    end
  endtask

  task automatic test_tie();
    int gc, rc;
    logic [DATA_W-1:0] d;
    req_a = 1'b1; we_a = 1'b1; addr_a = 3'd1; wdata_a = 16'h1111;
    req_b = 1'b1; we_b = 1'b1; addr_b = 3'd2; wdata_b = 16'h2222;
    @(negedge CLK);  // cycle 1
    checks++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || rf_address !== 3'd1 || rf_wr_data !== 16'h1111) begin
      failures++;
      $display("FAIL tie_first: gnt_a=%0b gnt_b=%0b addr=%0d data=%h, required 1 0 1 1111",
               gnt_a, gnt_b, rf_address, rf_wr_data);
    end
    req_a = 1'b0;
    @(negedge CLK);  // cycle 2
    checks++;
    if (gnt_b !== 1'b0) begin
      failures++;
      $display("FAIL tie_gap: gnt_b=%0b in cycle 2, required 0", gnt_b);
    end
    @(negedge CLK);  // cycle 3
    checks++;
    if (gnt_b !== 1'b1 || rf_address !== 3'd2 || rf_wr_data !== 16'h2222 || rf_wr_en !== 1'b1) begin
      failures++;
      $display("FAIL tie_second: gnt_b=%0b addr=%0d data=%h wr_en=%0b, required 1 2 2222 1",
               gnt_b, rf_address, rf_wr_data, rf_wr_en);
    end
    req_b = 1'b0;
    @(negedge CLK);
    // Read both back.
    send_cmd(1'b0, 1'b0, 3'd1, 16'h0, gc);
    wait_rvalid(1'b0, rc, d);
    checks++;
    if (gc !== 1 || rc !== 2 || d !== 16'h1111) begin
      failures++;
      $display("FAIL tie_read_a: gnt_cyc=%0d rvalid_cyc=%0d data=%h, required 1 2 1111", gc, rc, d);
    end
    send_cmd(1'b1, 1'b0, 3'd2, 16'h0, gc);
    wait_rvalid(1'b1, rc, d);
    checks++;
    if (gc !== 1 || rc !== 2 || d !== 16'h2222) begin
      failures++;
      $display("FAIL tie_read_b: gnt_cyc=%0d rvalid_cyc=%0d data=%h, required 1 2 2222", gc, rc, d);
    end
    checks++;
    if (rdata_a !== 16'h1111) begin
      failures++;
      $display("FAIL tie_rdata_a_held: rdata_a=%h, required 1111", rdata_a);
    end
  endtask

  task automatic test_continuous();
    logic got_b [8];
    int   n = 0;
    logic exp_b;
    do_reset();
    req_a = 1'b1; we_a = 1'b1; addr_a = 3'd4; wdata_a = 16'hAAAA;
    req_b = 1'b1; we_b = 1'b1; addr_b = 3'd5; wdata_b = 16'h5555;
    for (int c = 0; c < 40 && n < 8; c++) begin
      @(negedge CLK);
      if (gnt_a || gnt_b) begin
        got_b[n] = gnt_b;
        n++;
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL cont_count: grants=%0d within 40 cycles, required 8", n);
    end
    for (int i = 0; i < n; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_b = i[0];
`else
      exp_b = 1'b0;
`endif
      checks++;
      if (got_b[i] !== exp_b) begin
        failures++;
        $display("FAIL cont_order[%0d]: granted %s, required %s", i,
                 got_b[i] ? "B" : "A", exp_b ? "B" : "A");
      end
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset_mid_read();
    int gc, rc;
    logic [DATA_W-1:0] d;
    send_cmd(1'b0, 1'b0, 3'd1, 16'h0, gc);  // returns in cycle 1
    checks++;
    if (gc !== 1) begin
      failures++;
      $display("FAIL abort_gnt: gnt_cyc=%0d, required 1", gc);
    end
    @(negedge CLK);  // cycle 2 = RDWAIT
    checks++;
    if (dbg_state !== 2'd2) begin
      failures++;
      $display("FAIL abort_in_rdwait: state=%0d, required 2", dbg_state);
    end
    RST = 1'b0;
    #1;
    checks++;
    if ({gnt_a, gnt_b, rvalid_a, rvalid_b, rf_wr_en, rf_rd_en, busy, dbg_state} !== 9'b0 ||
        {rdata_a, rdata_b, rf_wr_data, rf_address} !== '0) begin
      failures++;
      $display("FAIL abort_async: ctrl=%b state=%0d rdata_a=%h rdata_b=%h wd=%h addr=%0d, required all 0",
               {gnt_a, gnt_b, rvalid_a, rvalid_b, rf_wr_en, rf_rd_en, busy}, dbg_state,
               rdata_a, rdata_b, rf_wr_data, rf_address);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      checks++;
      if (rvalid_a !== 1'b0) begin
        failures++;
        $display("FAIL abort_no_rvalid: rvalid_a=%0b during reset, required 0", rvalid_a);
      end
    end
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (rvalid_a !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_after: rvalid_a=%0b busy=%0b, required 0 0", rvalid_a, busy);
    end
    send_cmd(1'b0, 1'b0, 3'd1, 16'h0, gc);
    wait_rvalid(1'b0, rc, d);
    checks++;
    if (gc !== 1 || rc !== 2 || d !== 16'h1111) begin
      failures++;
      $display("FAIL abort_recover: gnt_cyc=%0d rvalid_cyc=%0d data=%h, required 1 2 1111", gc, rc, d);
    end
  endtask

  initial begin
    test_reset();
    test_write_a();
    test_read_b();
    test_tie();
    test_continuous();
    test_reset_mid_read();
    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
